// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEF_WIDTH);

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle over a shared
// 2*WIDTH accumulator; MTHI/MTLO write HI/LO directly while idle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, done_q, done_d;

  // Multiply step: conditionally add the multiplicand into the upper half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Restoring divide step: shift left, trial-subtract the divisor from the upper half.
  logic [WIDTH:0]     div_up;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_up   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_up >= {1'b0, opr_q});
    div_diff = div_up[WIDTH-1:0] - opr_q;
    div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[2*WIDTH-2:0], 1'b0};
  end

  logic             in_signed;
  logic             in_sa, in_sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opr_d     = opr_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    in_signed = is_signed_op(op_e'(op));
    in_sa     = in_signed & a[WIDTH-1];
    in_sb     = in_signed & b[WIDTH-1];
    mag_a     = in_sa ? -a : a;
    mag_b     = in_sb ? -b : b;
    prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;

    unique case (state_q)
      IDLE: begin
        if (mthi) hi_d = a;
        if (mtlo) lo_d = a;
        if (start) begin
          op_d  = op_e'(op);
          sa_d  = in_sa;
          sb_d  = in_sb;
          cnt_d = '0;
          dz_d  = is_div_op(op_e'(op)) && (b == '0);
          if (is_div_op(op_e'(op))) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opr_d = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            opr_d = mag_a;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = is_div_op(op_q) ? div_next : mul_next;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        if (is_div_op(op_q)) begin
          // Divide by zero keeps the dividend as remainder; only the quotient is forced.
          lo_d = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      opr_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a cycle-level arithmetic model checked every
// cycle, plus hand-computed HI/LO values at the documented result cycle.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model_result(input logic [1:0] mop,
                                                  input logic [W-1:0] ma,
                                                  input logic [W-1:0] mb);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    case (mop)
      2'b00: begin q = sa * sb; return q; end
      2'b01: begin uq = ua * ub; return uq; end
      2'b10: begin
        if (mb == '0) return {ma, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (mb == '0) return {ma, {W{1'b1}}};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[W-1:0], uq[W-1:0]};
      end
    endcase
  endfunction

  // Model: busy for WIDTH+1 cycles after an accepted start, then result + done.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    m_done = 1'b0;
    if (reset) begin
      m_cnt = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
      end
    end else begin
      if (mthi) m_hi = a;
      if (mtlo) m_lo = a;
      if (start) begin
        {p_hi, p_lo} = model_result(op, a, b);
        m_cnt = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_busy", {31'b0, busy}, {31'b0, (m_cnt != 0)});
      check("model_done", {31'b0, done}, {31'b0, m_done});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge inside cycle 1.
  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    start = 1'b1;
    op    = iop;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic run_op(input string name, input logic [1:0] iop,
                        input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    issue(iop, ia, ib);
    repeat (W + 1) @(negedge clk);
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    @(negedge clk);
    check({name, "_done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("div_zero_neg", 2'b10, 32'hFFFFFF00, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF);
    run_op("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);
    run_op("mult_pos", 2'b00, 32'h7FFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFE);

    // Idle MTLO, then MTHI plus a second start while busy must both be ignored.
    mtlo = 1'b1;
    a    = 32'hCAFE;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE);
    check("mtlo_hi", hi, 32'h0);
    issue(2'b01, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    mthi  = 1'b1;
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd99;
    b     = 32'd0;
    @(negedge clk);
    mthi  = 1'b0;
    start = 1'b0;
    check("busy_ign_busy", {31'b0, busy}, 32'd1);
    check("busy_ign_hi", hi, 32'h0);
    repeat (28) @(negedge clk);
    check("busy_ign_done", {31'b0, done}, 32'd1);
    check("busy_ign_res_lo", lo, 32'd12);
    check("busy_ign_res_hi", hi, 32'd0);
    repeat (3) @(negedge clk);

    // MTHI/MTLO together with start: the result overwrites both.
    mthi = 1'b1;
    mtlo = 1'b1;
    issue(2'b01, 32'h55, 32'd2);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mv_start_hi", hi, 32'h55);
    check("mv_start_lo", lo, 32'h55);
    repeat (W + 1) @(negedge clk);
    check("mv_start_res_lo", lo, 32'hAA);
    check("mv_start_res_hi", hi, 32'h0);
    @(negedge clk);

    // Reset in cycle 10 abandons the op with no done pulse.
    issue(2'b01, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    run_op("after_abort", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
